// File: rtl/ble_frame_parser.sv
`default_nettype none
// =============================================================================
// Module   : ble_frame_parser
// Brief    : Checks SYNC/CMD/LEN/payload/CHK frames from the BLE UART byte
//            stream and holds the last good frame behind a valid/ready port.
// Revision : 1.0 - initial release
// =============================================================================
module ble_frame_parser #(
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 742500,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid_in,
  input  logic                 frame_ready_in,
  output logic                 frame_valid_out,
  output logic [7:0]           cmd_out,
  output logic [3:0]           len_out,
  output logic [8*MAX_LEN-1:0] payload_out,
  output logic [7:0]           err_count_out,
  output logic [7:0]           drop_count_out,
  output logic                 busy_out
);

  localparam int                 c_timer_w      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         c_max_len      = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [7:0]             r_cmd;
  logic [3:0]             r_len;
  logic [7:0]             r_chk;
  logic [3:0]             r_idx;
  logic [8*MAX_LEN-1:0]   r_payload;
  logic [c_timer_w-1:0]   r_timer;

  logic w_expire;
  logic w_bad_len;
  logic w_bad_chk;
  logic w_commit;
  logic w_can_load;

  // An arriving byte always beats the gap timer in the expiry cycle.
  assign w_expire   = (r_state != ST_IDLE) && !byte_valid_in && (r_timer == c_timeout_last);
  assign w_bad_len  = byte_valid_in && (r_state == ST_LEN) && (byte_in > c_max_len);
  assign w_bad_chk  = byte_valid_in && (r_state == ST_CHECK) && (byte_in != r_chk);
  assign w_commit   = byte_valid_in && (r_state == ST_CHECK) && (byte_in == r_chk);
  assign w_can_load = !frame_valid_out || frame_ready_in;
  assign busy_out   = (r_state != ST_IDLE);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state         <= ST_IDLE;
      r_cmd           <= '0;
      r_len           <= '0;
      r_chk           <= '0;
      r_idx           <= '0;
      r_payload       <= '0;
      r_timer         <= '0;
      frame_valid_out <= 1'b0;
      cmd_out         <= '0;
      len_out         <= '0;
      payload_out     <= '0;
      err_count_out   <= '0;
      drop_count_out  <= '0;
    end else begin
      if (byte_valid_in || (r_state == ST_IDLE) || w_expire) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (byte_valid_in) begin
        case (r_state)
          ST_IDLE: begin
            if (byte_in == SYNC_BYTE) r_state <= ST_CMD;
          end
          ST_CMD: begin
            r_cmd   <= byte_in;
            r_chk   <= byte_in;
            r_state <= ST_LEN;
          end
          ST_LEN: begin
            if (w_bad_len) begin
              r_state <= ST_IDLE;
            end else begin
              r_len     <= byte_in[3:0];
              r_chk     <= r_chk ^ byte_in;
              r_idx     <= '0;
              r_payload <= '0;
              r_state   <= (byte_in == 8'd0) ? ST_CHECK : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            r_payload[8*r_idx +: 8] <= byte_in;
            r_chk                   <= r_chk ^ byte_in;
            r_idx                   <= r_idx + 4'd1;
            if (r_idx == r_len - 4'd1) r_state <= ST_CHECK;
          end
          ST_CHECK: begin
            r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_expire) begin
        r_state <= ST_IDLE;
      end

      // A commit may refill the register in the same cycle it is consumed.
      if (w_commit && w_can_load) begin
        frame_valid_out <= 1'b1;
        cmd_out         <= r_cmd;
        len_out         <= r_len;
        payload_out     <= r_payload;
      end else if (frame_valid_out && frame_ready_in) begin
        frame_valid_out <= 1'b0;
      end

      if (w_commit && !w_can_load && (drop_count_out != 8'hFF)) begin
        drop_count_out <= drop_count_out + 8'd1;
      end

      if ((w_expire || w_bad_len || w_bad_chk) && (err_count_out != 8'hFF)) begin
        err_count_out <= err_count_out + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
